// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART frame constants and transmitter state encoding
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int BAUD_W               = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count and flags, head visible combinationally
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      fill,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_wr, do_rd;

    // A full FIFO refuses writes even when a pop happens in the same cycle.
    assign do_wr = wr_en && !full_q;
    assign do_rd = rd_en && !empty_q;

    // Pointer, count and flag next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign fill  = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with overflow-flagged byte FIFO
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter  int DEPTH        = 8,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wdata,
    input  logic          clr_ovrflw,
    output logic          txd,
    output logic          tbr_valid,
    output logic          busy,
    output logic          overflow,
    output logic [AW:0]   fill
);

    localparam int              IDX_W     = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] RELOAD  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic                   overflow_q, overflow_d;
    logic                   pop;
    logic [7:0]             fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic                   bit_end;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .wdata (wdata),
        .rd_en (pop),
        .rdata (fifo_rdata),
        .fill  (fill),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_end = (baud_q == '0);

    // Frame sequencer: pops the FIFO head, walks start/data/stop bits, chains frames without a gap.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = RELOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = RELOAD;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d = RELOAD;
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_d = RELOAD;
                    if (idx_q == LAST_STOP) begin
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_rdata;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // txd follows the state being entered so the line changes on the same edge.
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // Sticky overflow; a dropped write beats a clear in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_en && fifo_full) overflow_d = 1'b1;
        else if (clr_ovrflw)    overflow_d = 1'b0;
    end

    // Transmitter state registers; reset drives the line idle high immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd       = txd_q;
    assign tbr_valid = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, clr_ovrflw;
    logic [7:0] wdata;
    logic       txd, tbr_valid, busy, overflow;
    logic [3:0] fill;

    logic       wr_en_1, clr_ovrflw_1;
    logic [7:0] wdata_1;
    logic       txd_1, tbr_valid_1, busy_1, overflow_1;
    logic [3:0] fill_1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];
    logic       sb1 [$];
    logic       mon_en;
    logic [7:0] mon_byte;
    logic       mon_stop;
    int         n;
    int         lows;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .clr_ovrflw(clr_ovrflw),
        .txd(txd), .tbr_valid(tbr_valid), .busy(busy), .overflow(overflow), .fill(fill)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(1), .DEPTH(8)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en_1), .wdata(wdata_1), .clr_ovrflw(clr_ovrflw_1),
        .txd(txd_1), .tbr_valid(tbr_valid_1), .busy(busy_1), .overflow(overflow_1), .fill(fill_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit accept);
        wr_en = 1'b1;
        wdata = b;
        if (accept && mon_en) sb.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Serial decoder: samples each bit one half-cycle after it starts and scores the byte.
    always begin
        @(negedge clk);
        if (mon_en && !txd) begin
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_byte[i] = txd;
            end
            repeat (CPB) @(negedge clk);
            mon_stop = txd;
            check("stop_bit", 32'(mon_stop), 32'd1);
            check("frame_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("frame_byte", 32'(mon_byte), 32'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wdata = 8'h00; clr_ovrflw = 1'b0;
        wr_en_1 = 1'b0; wdata_1 = 8'h00; clr_ovrflw_1 = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_txd", 32'(txd), 32'd1);
        check("rst_tbr_valid", 32'(tbr_valid), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_txd_1", 32'(txd_1), 32'd1);

        // Single byte: latency and frame length
        wr(8'h55, 1'b1);
        check("t1_fill_after_write", 32'(fill), 32'd1);
        check("t1_txd_before_pop", 32'(txd), 32'd1);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("t1_start_low", 32'(txd), 32'd0);
                check("t1_fill_after_pop", 32'(fill), 32'd0);
            end
        end
        check("t1_busy_cycles", 32'(n), 32'd41);
        repeat (3) @(negedge clk);

        // Back-to-back frames
        wr(8'hA3, 1'b1);
        wr(8'h0F, 1'b1);
        check("t2_fill_write_pop", 32'(fill), 32'd1);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 20) check("t2_fill_mid_frame", 32'(fill), 32'd1);
        end
        check("t2_busy_cycles", 32'(n), 32'd80);
        repeat (3) @(negedge clk);

        // Fill to full, drop, clear, simultaneous clear and drop
        for (int b = 0; b < 9; b++) wr(8'(b), 1'b1);
        check("t3_fill_full", 32'(fill), 32'd8);
        check("t3_tbr_valid_full", 32'(tbr_valid), 32'd0);
        check("t3_no_overflow_yet", 32'(overflow), 32'd0);
        wr(8'h09, 1'b0);
        check("t3_overflow_set", 32'(overflow), 32'd1);
        check("t3_fill_after_drop", 32'(fill), 32'd8);
        clr_ovrflw = 1'b1;
        @(negedge clk);
        clr_ovrflw = 1'b0;
        check("t3_overflow_cleared", 32'(overflow), 32'd0);
        wr_en = 1'b1; wdata = 8'h0A; clr_ovrflw = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; clr_ovrflw = 1'b0;
        check("t4_set_beats_clear", 32'(overflow), 32'd1);
        check("t4_fill_still_full", 32'(fill), 32'd8);
        clr_ovrflw = 1'b1;
        @(negedge clk);
        clr_ovrflw = 1'b0;
        wait_idle("t3_drain", 1000);
        repeat (3) @(negedge clk);
        check("t3_scoreboard_empty", 32'(sb.size()), 32'd0);
        check("t3_tbr_valid_empty", 32'(tbr_valid), 32'd1);

        // Reset during DATA bit 3 of 0xFF with three bytes queued
        mon_en = 1'b0;
        wr(8'hFF, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        wr(8'h33, 1'b1);
        repeat (15) @(negedge clk);
        check("t5_fill_queued", 32'(fill), 32'd3);
        check("t5_busy_pre", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_async_txd", 32'(txd), 32'd1);
        check("t5_async_fill", 32'(fill), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!txd) lows++;
        end
        check("t5_no_frame_after_reset", 32'(lows), 32'd0);
        check("t5_busy_after", 32'(busy), 32'd0);

        // Reset while the start bit is low must raise txd before any clock edge
        wr(8'h00, 1'b1);
        @(negedge clk);
        check("t5b_start_low", 32'(txd), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("t5b_async_txd_high", 32'(txd), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // CLKS_PER_BIT=1 build: 0xC6 frame bit by bit, then idle
        sb1.push_back(1'b0);
        for (int i = 0; i < 8; i++) sb1.push_back(1'((8'hC6 >> i) & 8'h01));
        sb1.push_back(1'b1);
        sb1.push_back(1'b1);
        wr_en_1 = 1'b1;
        wdata_1 = 8'hC6;
        @(negedge clk);
        wr_en_1 = 1'b0;
        while (sb1.size() != 0) begin
            @(negedge clk);
            check("t6_bit", 32'(txd_1), 32'(sb1.pop_front()));
        end
        check("t6_busy_done", 32'(busy_1), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
